ibex_bcp_region_alloc: RTL and testbench

- Writer side of the bounds-checking region table: services allocate/free requests and maintains the base/bound region entries and per-pair valid bits that the bound checker reads.
- An allocate claims a free region pair, writes base and bound, and returns a tagged pointer whose tag selects that pair.
- A free validates the pointer's tag and releases its pair.
- Sits beside the CSR file; its outputs drive the checker's region address inputs.

---
 rtl/ibex_bcp_region_alloc.sv | 165 ++++++++++++++++
 tb/tb_ibex_bcp_region_alloc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_bcp_region_alloc.sv
// ============================================================================
//  Module   : ibex_bcp_region_alloc
//  Function : Writer side of the bounds-checking region table. It services
//             allocate/free requests, maintains base/bound pairs and per-pair
//             valid bits, and returns tagged pointers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ibex_bcp_region_alloc #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned BCPNumRegions = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                lock_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic                                req_op_i,
    input  logic [XLEN-1:0]                     req_a_i,
    input  logic [XLEN-1:0]                     req_b_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic                                rsp_err_o,
    output logic [XLEN-1:0]                     rsp_ptr_o,
    output logic [BCPNumRegions-1:0][XLEN-1:0]  bcp_addr_o,
    output logic [BCPNumRegions/2-1:0]          bcp_region_valid_o
);

    localparam int unsigned ALEN     = XLEN / 4 * 3;
    localparam int unsigned TagWidth = XLEN - ALEN;
    localparam int unsigned NumPairs = BCPNumRegions / 2;
    localparam int unsigned RIDX     = $clog2(BCPNumRegions);
    localparam int unsigned PIDX     = RIDX - 1;

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_search = 3'd1;
    localparam logic [2:0] c_write  = 3'd2;
    localparam logic [2:0] c_free   = 3'd3;
    localparam logic [2:0] c_resp   = 3'd4;

    logic [2:0]                              state_q, state_d;
    logic                                    op_q, op_d;
    logic [XLEN-1:0]                         a_q, a_d, b_q, b_d;
    logic [PIDX-1:0]                         idx_q, idx_d;
    logic                                    err_q, err_d;
    logic [XLEN-1:0]                         ptr_q, ptr_d;
    logic [NumPairs-1:0]                     valid_q, valid_d;
    logic [BCPNumRegions-1:0][XLEN-1:0]      addr_q, addr_d;

    logic [ALEN:0]         w_sum;
    logic                  w_pre_err;
    logic [TagWidth-1:0]   w_tag;
    logic [PIDX-1:0]       w_free_k;
    logic                  w_free_err;

    // The carry bit of the widened sum flags a region wrapping past the address space.
    assign w_sum     = {1'b0, a_q[ALEN-1:0]} + {1'b0, b_q[ALEN-1:0]};
    assign w_pre_err = lock_i | (|a_q[XLEN-1:ALEN]) | (b_q == '0)
                     | (|b_q[XLEN-1:ALEN]) | w_sum[ALEN];

    assign w_tag      = a_q[XLEN-1:ALEN];
    assign w_free_k   = w_tag[RIDX-1:1];
    assign w_free_err = lock_i | (w_tag == '0) | (&w_tag) | ~w_tag[0]
                      | (w_tag >= TagWidth'(BCPNumRegions)) | ~valid_q[w_free_k];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= c_idle;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        case (state_q)
            c_idle: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    idx_d   = '0;
                    state_d = req_op_i ? c_free : c_search;
                end
            end
            c_search: begin
                // Index 0 is only ever seen in the first scan cycle, so prechecks key off it.
                if ((idx_q == '0) && w_pre_err) begin
                    err_d   = 1'b1;
                    ptr_d   = '0;
                    state_d = c_resp;
                end else if (!valid_q[idx_q]) begin
                    state_d = c_write;
                end else if (idx_q == PIDX'(NumPairs - 1)) begin
                    err_d   = 1'b1;
                    ptr_d   = '0;
                    state_d = c_resp;
                end else begin
                    idx_d = idx_q + PIDX'(1);
                end
            end
            c_write: begin
                addr_d[{idx_q, 1'b0}] = {{TagWidth{1'b0}}, a_q[ALEN-1:0]};
                addr_d[{idx_q, 1'b1}] = {{TagWidth{1'b0}}, w_sum[ALEN-1:0]};
                valid_d[idx_q]        = 1'b1;
                ptr_d                 = {TagWidth'({idx_q, 1'b1}), a_q[ALEN-1:0]};
                err_d                 = 1'b0;
                state_d               = c_resp;
            end
            c_free: begin
                ptr_d = '0;
                err_d = w_free_err;
                if (!w_free_err) begin
                    valid_d[w_free_k]        = 1'b0;
                    addr_d[{w_free_k, 1'b0}] = '0;
                    addr_d[{w_free_k, 1'b1}] = '0;
                end
                state_d = c_resp;
            end
            c_resp: begin
                if (rsp_ready_i) begin
                    state_d = c_idle;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        req_ready_o        = (state_q == c_idle);
        rsp_valid_o        = (state_q == c_resp);
        rsp_err_o          = rsp_valid_o & err_q;
        rsp_ptr_o          = rsp_valid_o ? ptr_q : '0;
        bcp_addr_o         = addr_q;
        bcp_region_valid_o = valid_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ibex_bcp_region_alloc.sv
// ============================================================================
//  Module   : tb_ibex_bcp_region_alloc
//  Function : Self-checking bench for the region allocator; expected
//             responses are queued when a request is issued and compared
//             when the response arrives.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_bcp_region_alloc;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lock = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_op = 1'b0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_err;
    logic [31:0]      rsp_ptr;
    logic [3:0][31:0] bcp_addr;
    logic [1:0]       bcp_valid;

    typedef struct {
        logic        err;
        logic [31:0] ptr;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ibex_bcp_region_alloc #(.XLEN(32), .BCPNumRegions(4)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .lock_i             (lock),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_op_i           (req_op),
        .req_a_i            (req_a),
        .req_b_i            (req_b),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_err_o          (rsp_err),
        .rsp_ptr_o          (rsp_ptr),
        .bcp_addr_o         (bcp_addr),
        .bcp_region_valid_o (bcp_valid)
    );

    // Latency counts the accept edge as cycle 1; a timeout shows up as a latency mismatch.
    task automatic do_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                          output logic err, output logic [31:0] ptr, output int lat);
        int w;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        lat = 1;
        #1 req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; #1; end
        err = rsp_err; ptr = rsp_ptr;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_ptr !== 32'h0
            || bcp_addr !== 128'h0 || bcp_valid !== 2'b00)
            $display("FAIL reset_state: rdy=%b vld=%b err=%b ptr=%h valid=%b addr=%h, want rdy=1 rest 0",
                     req_ready, rsp_valid, rsp_err, rsp_ptr, bcp_valid, bcp_addr);
        else passed++;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_alloc();
        logic [31:0] a_t [3] = '{32'h00001000, 32'h00002000, 32'h00003000};
        logic [31:0] b_t [3] = '{32'h00000100, 32'h00000040, 32'h00000010};
        exp_t        e_t [3] = '{'{1'b0, 32'h01001000, 3}, '{1'b0, 32'h03002000, 4}, '{1'b1, 32'h0, 3}};
        logic [1:0]  v_t [3] = '{2'b01, 2'b11, 2'b11};
        logic [3:0][31:0] tbl;
        logic err; logic [31:0] ptr; int lat; exp_t e;
        tbl = '0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(e_t[i]);
            do_req(1'b0, a_t[i], b_t[i], err, ptr, lat);
            e = sb.pop_front();
            total++;
            if (err !== e.err || ptr !== e.ptr || lat !== e.lat)
                $display("FAIL alloc%0d: err=%b ptr=%h lat=%0d, want err=%b ptr=%h lat=%0d",
                         i, err, ptr, lat, e.err, e.ptr, e.lat);
            else passed++;
            if (i < 2) begin
                tbl[2*i]   = a_t[i];
                tbl[2*i+1] = a_t[i] + b_t[i];
            end
            total++;
            if (bcp_addr !== tbl || bcp_valid !== v_t[i])
                $display("FAIL alloc%0d_table: valid=%b addr=%h, want valid=%b addr=%h",
                         i, bcp_valid, bcp_addr, v_t[i], tbl);
            else passed++;
        end
    endtask

    task automatic test_free();
        logic [31:0] p_t [5] = '{32'h01001234, 32'h01001234, 32'hFF000000, 32'h02000000, 32'h05000000};
        logic        x_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0][31:0] tbl;
        logic err; logic [31:0] ptr; int lat; exp_t e;
        tbl = '0;
        tbl[2] = 32'h00002000;
        tbl[3] = 32'h00002040;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{x_t[i], 32'h0, 2});
            do_req(1'b1, p_t[i], 32'h0, err, ptr, lat);
            e = sb.pop_front();
            total++;
            if (err !== e.err || ptr !== e.ptr || lat !== e.lat)
                $display("FAIL free%0d(%h): err=%b ptr=%h lat=%0d, want err=%b ptr=%h lat=%0d",
                         i, p_t[i], err, ptr, lat, e.err, e.ptr, e.lat);
            else passed++;
            total++;
            if (bcp_addr !== tbl || bcp_valid !== 2'b10)
                $display("FAIL free%0d_table: valid=%b addr=%h, want valid=10 addr=%h",
                         i, bcp_valid, bcp_addr, tbl);
            else passed++;
        end
    endtask

    task automatic test_alloc_errors();
        logic [31:0] a_t [5] = '{32'h00FFFF00, 32'h00005000, 32'h01000000, 32'h00005000, 32'h00005000};
        logic [31:0] b_t [5] = '{32'h00000200, 32'h00000000, 32'h00000010, 32'h01000000, 32'h00000010};
        logic        l_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0][31:0] tbl;
        logic err; logic [31:0] ptr; int lat; exp_t e;
        tbl = '0;
        tbl[2] = 32'h00002000;
        tbl[3] = 32'h00002040;
        for (int i = 0; i < 5; i++) begin
            lock = l_t[i];
            sb.push_back('{1'b1, 32'h0, 2});
            do_req(1'b0, a_t[i], b_t[i], err, ptr, lat);
            e = sb.pop_front();
            total++;
            if (err !== e.err || ptr !== e.ptr || lat !== e.lat)
                $display("FAIL alloc_err%0d: err=%b ptr=%h lat=%0d, want err=%b ptr=%h lat=%0d",
                         i, err, ptr, lat, e.err, e.ptr, e.lat);
            else passed++;
            total++;
            if (bcp_addr !== tbl || bcp_valid !== 2'b10)
                $display("FAIL alloc_err%0d_table: valid=%b addr=%h, want valid=10 addr=%h",
                         i, bcp_valid, bcp_addr, tbl);
            else passed++;
        end
        // A locked free of a live pair must also be refused.
        lock = 1'b1;
        sb.push_back('{1'b1, 32'h0, 2});
        do_req(1'b1, 32'h03002000, 32'h0, err, ptr, lat);
        e = sb.pop_front();
        lock = 1'b0;
        total++;
        if (err !== e.err || lat !== e.lat || bcp_valid !== 2'b10)
            $display("FAIL free_locked: err=%b lat=%0d valid=%b, want err=1 lat=2 valid=10", err, lat, bcp_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [3:0][31:0] tbl;
        int lat; exp_t e;
        sb.push_back('{1'b0, 32'h01004000, 3});
        sb.push_back('{1'b0, 32'h0, 2});
        @(negedge clk);
        req_op = 1'b0; req_a = 32'h00004000; req_b = 32'h00000080; req_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; #1; end
        e = sb.pop_front();
        total++;
        if (rsp_err !== e.err || rsp_ptr !== e.ptr || lat !== e.lat)
            $display("FAIL bp_alloc: err=%b ptr=%h lat=%0d, want err=%b ptr=%h lat=%0d",
                     rsp_err, rsp_ptr, lat, e.err, e.ptr, e.lat);
        else passed++;
        req_op = 1'b1; req_a = 32'h03002000; req_b = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_err !== e.err || rsp_ptr !== e.ptr || req_ready !== 1'b0)
                $display("FAIL bp_hold%0d: vld=%b err=%b ptr=%h rdy=%b, want vld=1 err=%b ptr=%h rdy=0",
                         i, rsp_valid, rsp_err, rsp_ptr, req_ready, e.err, e.ptr);
            else passed++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL bp_after_handshake: rdy=%b vld=%b, want rdy=1 vld=0", req_ready, rsp_valid);
        else passed++;
        @(posedge clk);
        lat = 1;
        #1 req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; #1; end
        e = sb.pop_front();
        total++;
        if (rsp_err !== e.err || rsp_ptr !== e.ptr || lat !== e.lat)
            $display("FAIL bp_free: err=%b ptr=%h lat=%0d, want err=%b ptr=%h lat=%0d",
                     rsp_err, rsp_ptr, lat, e.err, e.ptr, e.lat);
        else passed++;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        tbl = '0;
        tbl[0] = 32'h00004000;
        tbl[1] = 32'h00004080;
        total++;
        if (bcp_addr !== tbl || bcp_valid !== 2'b01)
            $display("FAIL bp_table: valid=%b addr=%h, want valid=01 addr=%h", bcp_valid, bcp_addr, tbl);
        else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_op = 1'b0; req_a = 32'h00006000; req_b = 32'h00000010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_ptr !== 32'h0
            || bcp_addr !== 128'h0 || bcp_valid !== 2'b00)
            $display("FAIL reset_mid: rdy=%b vld=%b err=%b ptr=%h valid=%b addr=%h, want rdy=1 rest 0",
                     req_ready, rsp_valid, rsp_err, rsp_ptr, bcp_valid, bcp_addr);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || bcp_valid !== 2'b00 || bcp_addr !== 128'h0 || req_ready !== 1'b1)
            $display("FAIL reset_mid_after: vld=%b valid=%b addr=%h rdy=%b, want vld=0 valid=00 addr=0 rdy=1",
                     rsp_valid, bcp_valid, bcp_addr, req_ready);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_free();
        test_alloc_errors();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
